// File: rtl/servo_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : servo_seq_pkg
//  Purpose : Shared definitions for the servo sequencer: the mode/state
//            encoding, which is shared by cmd_mode and the state output, and
//            a helper that returns the mid-scale (center) servo position.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package servo_seq_pkg;

   // cmd_mode and state use this same encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LIVE = 2'b01,
      ST_REC  = 2'b10,
      ST_PLAY = 2'b11
   } state_t;

   // Mid-scale position for a data_w-bit position value: 2**(data_w-1).
   function automatic int unsigned center_pos(input int unsigned data_w);
      return 32'd1 << (data_w - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/servo_seq_ram.sv
`default_nettype none
// ============================================================================
//  Module  : servo_seq_ram
//  Purpose : Simple dual-port trajectory RAM. Synchronous write, synchronous
//            read with one cycle of latency and no reset, so it maps onto
//            block RAM.
//  Ports   : clk_i                  clock
//            wr_en_i/wr_addr_i/wr_data_i   write port
//            rd_en_i/rd_addr_i      read request (data valid next cycle)
//            rd_data_o              registered read data
//  Rev     : 1.0  initial release
// ============================================================================
module servo_seq_ram #(
   parameter int WIDTH  = 24,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/servo_seq.sv
`default_nettype none
// ============================================================================
//  Module  : servo_seq
//  Purpose : Multi-channel servo PWM sequencer. Each channel's target is
//            taken from live positions or from a recorded trajectory played
//            back from RAM. Each frame the position slews toward the target,
//            and the position is turned into a pulse width.
//  Ports   : clk_i, rst_ni (async active-low)
//            en_i          PWM output enable
//            start_i       command strobe, latches cmd_mode_i
//            cmd_mode_i    IDLE/LIVE/REC/PLAY
//            loop_i        looped playback
//            live_pos_i    live positions, channel i at [i*DATA_W +: DATA_W]
//            pwm_out_o     servo pulses
//            pos_out_o     current slewed positions
//            state_o       current state
//            rec_len_o     recorded sample count
//            full_o        last recording stopped on DEPTH
//            done_o        one-cycle pulse at end of non-looping playback
//  Rev     : 1.0  initial release
// ============================================================================
module servo_seq
   import servo_seq_pkg::*;
#(
   parameter  int NUM_CH     = 3,
   parameter  int DATA_W     = 8,
   parameter  int DEPTH      = 256,
   parameter  int PERIOD_CYC = 1_000_000,
   parameter  int PULSE_MIN  = 50_000,
   parameter  int STEP_CYC   = 196,
   parameter  int SLEW_MAX   = 4,
   localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     start_i,
   input  logic [1:0]               cmd_mode_i,
   input  logic                     loop_i,
   input  logic [NUM_CH*DATA_W-1:0] live_pos_i,
   output logic [NUM_CH-1:0]        pwm_out_o,
   output logic [NUM_CH*DATA_W-1:0] pos_out_o,
   output logic [1:0]               state_o,
   output logic [ADDR_W:0]          rec_len_o,
   output logic                     full_o,
   output logic                     done_o
);

   localparam int CNT_W      = $clog2(PERIOD_CYC + 1);
   localparam int LW         = NUM_CH * DATA_W;
   localparam int POS_MAX    = (2 ** DATA_W) - 1;
   localparam int SLEW_CLAMP = (SLEW_MAX > POS_MAX) ? POS_MAX : SLEW_MAX;

   localparam logic [CNT_W-1:0]  SAMPLE_PT  = CNT_W'(PERIOD_CYC / 2);
   localparam logic [CNT_W-1:0]  PRE_SAMPLE = CNT_W'(PERIOD_CYC / 2 - 1);
   localparam logic [CNT_W-1:0]  FRAME_END  = CNT_W'(PERIOD_CYC - 1);
   localparam logic [DATA_W-1:0] CENTER     = DATA_W'(center_pos(DATA_W));
   localparam logic [DATA_W-1:0] SLEW_STEP  = DATA_W'(SLEW_CLAMP);
   localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_L      = (ADDR_W + 1)'(1);

   // The widest pulse must still fit inside one frame.
   if (PULSE_MIN + POS_MAX * STEP_CYC > PERIOD_CYC) begin : g_pulse_range_err
      $error("servo_seq: PULSE_MIN + max position * STEP_CYC exceeds PERIOD_CYC");
   end

   // ------------------------------------------------------------------------
   // Frame counter and frame timing strobes
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] frame_cnt_q;
   logic             sample_pt;
   logic             pre_sample;
   logic             frame_end;

   assign sample_pt  = (frame_cnt_q == SAMPLE_PT);
   assign pre_sample = (frame_cnt_q == PRE_SAMPLE);
   assign frame_end  = (frame_cnt_q == FRAME_END);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt_q <= '0;
      end else if (frame_end) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer FSM with record/playback pointers
   // ------------------------------------------------------------------------
   state_t              state_q,   state_d;
   logic                done_q,    done_d;
   logic                full_q,    full_d;
   logic [ADDR_W:0]     rec_len_q, rec_len_d;
   logic [ADDR_W-1:0]   wr_ptr_q,  wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q,  rd_ptr_d;
   logic                wr_en;
   logic                rd_en;
   logic                ld_live;
   logic                ld_mem;
   logic [LW-1:0]       rd_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         done_q    <= 1'b0;
         full_q    <= 1'b0;
         rec_len_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         full_q    <= full_d;
         rec_len_q <= rec_len_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      full_d    = full_q;
      rec_len_d = rec_len_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      ld_live   = 1'b0;
      ld_mem    = 1'b0;

      // The current state's sample is processed even if start arrives on
      // the same cycle; start only overrides the resulting transition.
      case (state_q)
         ST_LIVE: begin
            ld_live = sample_pt;
         end
         ST_REC: begin
            if (sample_pt) begin
               wr_en     = 1'b1;
               ld_live   = 1'b1;
               wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
               rec_len_d = rec_len_q + ONE_L;
               if (rec_len_q == DEPTH_L - ONE_L) begin
                  full_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_PLAY: begin
            if (rec_len_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               // Read one cycle early so RAM data is ready at the sample point.
               rd_en = pre_sample;
               if (sample_pt) begin
                  ld_mem = 1'b1;
                  if ({1'b0, rd_ptr_q} == rec_len_q - ONE_L) begin
                     if (loop_i) begin
                        rd_ptr_d = '0;
                     end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end else begin
                     rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase

      if (start_i) begin
         state_d = state_t'(cmd_mode_i);
         done_d  = 1'b0;
         if (cmd_mode_i == ST_REC) begin
            wr_ptr_d  = '0;
            rec_len_d = '0;
            full_d    = 1'b0;
         end
         if (cmd_mode_i == ST_PLAY) begin
            rd_ptr_d = '0;
         end
      end
   end

   servo_seq_ram #(
      .WIDTH  (LW),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (live_pos_i),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   // ------------------------------------------------------------------------
   // Per-channel target, slew limiter and pulse generator
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DATA_W-1:0] live_w;
      logic [DATA_W-1:0] mem_w;
      logic [DATA_W-1:0] tgt_q;
      logic [DATA_W-1:0] pos_q, pos_d;
      logic [CNT_W-1:0]  pulse_cyc;
      logic              pwm_q;

      assign live_w = live_pos_i[i*DATA_W +: DATA_W];
      assign mem_w  = rd_data[i*DATA_W +: DATA_W];

      // Step toward the target, never overshooting it.
      always_comb begin
         pos_d = pos_q;
         if (SLEW_MAX == 0) begin
            pos_d = tgt_q;
         end else if (tgt_q > pos_q) begin
            pos_d = ((tgt_q - pos_q) > SLEW_STEP) ? (pos_q + SLEW_STEP) : tgt_q;
         end else if (pos_q > tgt_q) begin
            pos_d = ((pos_q - tgt_q) > SLEW_STEP) ? (pos_q - SLEW_STEP) : tgt_q;
         end
      end

      assign pulse_cyc = CNT_W'(PULSE_MIN + 32'(pos_q) * STEP_CYC);

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            tgt_q <= CENTER;
            pos_q <= CENTER;
            pwm_q <= 1'b0;
         end else begin
            if (ld_live) begin
               tgt_q <= live_w;
            end else if (ld_mem) begin
               tgt_q <= mem_w;
            end
            // Position only moves at the frame boundary so each pulse is whole.
            if (frame_end) begin
               pos_q <= pos_d;
            end
            pwm_q <= en_i && (frame_cnt_q < pulse_cyc);
         end
      end

      assign pwm_out_o[i]                  = pwm_q;
      assign pos_out_o[i*DATA_W +: DATA_W] = pos_q;
   end

   assign state_o   = state_q;
   assign rec_len_o = rec_len_q;
   assign full_o    = full_q;
   assign done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_servo_seq
//  Purpose : Directed testbench for servo_seq. Two instances share the
//            stimulus: dut0 without slew limiting and dut1 with SLEW_MAX=1.
//            Frame length is 100 cycles, sample point at count 50.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_servo_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        start;
   logic [1:0]  cmd;
   logic        loop;
   logic [11:0] live;

   logic [1:0]  pwm0,  pwm1;
   logic [11:0] pos0,  pos1;
   logic [1:0]  st0,   st1;
   logic [2:0]  rl0,   rl1;
   logic        full0, full1;
   logic        done0, done1;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   servo_seq #(
      .NUM_CH(2), .DATA_W(6), .DEPTH(4), .PERIOD_CYC(100),
      .PULSE_MIN(10), .STEP_CYC(1), .SLEW_MAX(0)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start),
      .cmd_mode_i(cmd), .loop_i(loop), .live_pos_i(live),
      .pwm_out_o(pwm0), .pos_out_o(pos0), .state_o(st0),
      .rec_len_o(rl0), .full_o(full0), .done_o(done0)
   );

   servo_seq #(
      .NUM_CH(2), .DATA_W(6), .DEPTH(4), .PERIOD_CYC(100),
      .PULSE_MIN(10), .STEP_CYC(1), .SLEW_MAX(1)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start),
      .cmd_mode_i(cmd), .loop_i(loop), .live_pos_i(live),
      .pwm_out_o(pwm1), .pos_out_o(pos1), .state_o(st1),
      .rec_len_o(rl1), .full_o(full1), .done_o(done1)
   );

   // Advance one clock; inputs are driven and outputs sampled 1 time unit
   // after the edge. cyc mirrors the DUT frame counter (cyc % 100).
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   // Count high cycles of each dut0 channel over one full frame.
   task automatic measure(output int w0, output int w1);
      w0 = 0;
      w1 = 0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (pwm0[0] === 1'b1) w0++;
         if (pwm0[1] === 1'b1) w1++;
      end
   endtask

   task automatic pulse_start(input logic [1:0] mode);
      cmd   = mode;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      int w0, w1;
      rst_n = 1'b0; en = 1'b1; start = 1'b0; cmd = 2'b00; loop = 1'b0; live = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      n_chk++; if (st0 !== 2'b00) $display("FAIL reset_state: got %0d want 0", st0); else n_pass++;
      n_chk++; if (rl0 !== 3'd0) $display("FAIL reset_rec_len: got %0d want 0", rl0); else n_pass++;
      n_chk++; if (full0 !== 1'b0 || done0 !== 1'b0) $display("FAIL reset_flags: full %b done %b want 0 0", full0, done0); else n_pass++;
      n_chk++; if (pwm0 !== 2'b00) $display("FAIL reset_pwm: got %b want 00", pwm0); else n_pass++;
      n_chk++; if (pos0 !== {6'd32, 6'd32}) $display("FAIL reset_pos: got %h want %h", pos0, {6'd32, 6'd32}); else n_pass++;
      measure(w0, w1);
      n_chk++; if (w0 !== 42) $display("FAIL reset_pulse_ch0: got %0d want 42", w0); else n_pass++;
      n_chk++; if (w1 !== 42) $display("FAIL reset_pulse_ch1: got %0d want 42", w1); else n_pass++;
   endtask

   task automatic test_live();
      int w0, w1;
      run_to(100);
      live = {6'd50, 6'd0};
      pulse_start(2'b01);
      n_chk++; if (st0 !== 2'b01) $display("FAIL live_state: got %0d want 1", st0); else n_pass++;
      run_to(200);
      measure(w0, w1);
      n_chk++; if (w0 !== 10) $display("FAIL live_pulse_ch0: got %0d want 10", w0); else n_pass++;
      n_chk++; if (w1 !== 60) $display("FAIL live_pulse_ch1: got %0d want 60", w1); else n_pass++;
      n_chk++; if (pos0 !== {6'd50, 6'd0}) $display("FAIL live_pos: got %h want %h", pos0, {6'd50, 6'd0}); else n_pass++;
      n_chk++; if (pos1 !== {6'd34, 6'd30}) $display("FAIL live_slew_pos: got %h want %h", pos1, {6'd34, 6'd30}); else n_pass++;
      en = 1'b0;
      measure(w0, w1);
      n_chk++; if (w0 !== 0 || w1 !== 0) $display("FAIL en_low_pwm: got %0d %0d want 0 0", w0, w1); else n_pass++;
      en = 1'b1;
   endtask

   task automatic test_rec();
      logic [11:0] e;
      run_to(400);
      live = {6'd9, 6'd1};
      pulse_start(2'b10);
      n_chk++; if (st0 !== 2'b10 || rl0 !== 3'd0) $display("FAIL rec_entry: state %0d rec_len %0d want 2 0", st0, rl0); else n_pass++;
      for (int k = 1; k <= 6; k++) begin
         live = {6'(k + 8), 6'(k)};
         if (k == 4) begin
            run_to(750);
            n_chk++; if (st0 !== 2'b10 || full0 !== 1'b0) $display("FAIL rec_before_last: state %0d full %b want 2 0", st0, full0); else n_pass++;
            tick();
            n_chk++; if (st0 !== 2'b00 || full0 !== 1'b1 || rl0 !== 3'd4) $display("FAIL rec_full: state %0d full %b rec_len %0d want 0 1 4", st0, full0, rl0); else n_pass++;
         end
         run_to(400 + 100 * k);
         if (k == 1) begin
            n_chk++; if (rl0 !== 3'd1 || st0 !== 2'b10) $display("FAIL rec_first: rec_len %0d state %0d want 1 2", rl0, st0); else n_pass++;
         end
      end
      n_chk++; if (rl0 !== 3'd4 || st0 !== 2'b00) $display("FAIL rec_after: rec_len %0d state %0d want 4 0", rl0, st0); else n_pass++;
      n_chk++; if (pos0 !== {6'd12, 6'd4}) $display("FAIL rec_pos: got %h want %h", pos0, {6'd12, 6'd4}); else n_pass++;
      n_chk++; if (pos1 !== {6'd29, 6'd23}) $display("FAIL rec_slew_pos: got %h want %h", pos1, {6'd29, 6'd23}); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         e = {6'(i + 9), 6'(i + 1)};
         n_chk++; if (dut0.u_ram.mem_q[i] !== e) $display("FAIL rec_ram[%0d]: got %h want %h", i, dut0.u_ram.mem_q[i], e); else n_pass++;
      end
   endtask

   task automatic test_play_once();
      int n_done  = 0;
      int done_at = -1;
      int k;
      run_to(1000);
      loop = 1'b0;
      pulse_start(2'b11);
      n_chk++; if (st0 !== 2'b11) $display("FAIL play_state: got %0d want 3", st0); else n_pass++;
      while (cyc < 1400) begin
         tick();
         if (done0 === 1'b1) begin
            n_done++;
            done_at = cyc;
         end
         if (cyc % 100 == 0) begin
            k = (cyc - 1000) / 100;
            n_chk++; if (pos0 !== {6'(k + 8), 6'(k)}) $display("FAIL play_pos_f%0d: got %h want %h", k, pos0, {6'(k + 8), 6'(k)}); else n_pass++;
         end
      end
      n_chk++; if (n_done !== 1 || done_at !== 1351) $display("FAIL play_done: count %0d at %0d want 1 at 1351", n_done, done_at); else n_pass++;
      n_chk++; if (st0 !== 2'b00) $display("FAIL play_end_state: got %0d want 0", st0); else n_pass++;
      run_to(1500);
      n_chk++; if (pos0 !== {6'd12, 6'd4}) $display("FAIL play_hold_pos: got %h want %h", pos0, {6'd12, 6'd4}); else n_pass++;
   endtask

   task automatic test_play_loop();
      int n_done = 0;
      int k, v;
      loop = 1'b1;
      pulse_start(2'b11);
      while (cyc < 2000) begin
         tick();
         if (done0 === 1'b1 || done1 === 1'b1) n_done++;
         if (cyc % 100 == 0) begin
            k = (cyc - 1500) / 100;
            v = ((k - 1) % 4) + 1;
            n_chk++; if (pos0 !== {6'(v + 8), 6'(v)}) $display("FAIL loop_pos_f%0d: got %h want %h", k, pos0, {6'(v + 8), 6'(v)}); else n_pass++;
            n_chk++; if (pos1 !== {6'(24 - k), 6'(18 - k)}) $display("FAIL loop_slew_f%0d: got %h want %h", k, pos1, {6'(24 - k), 6'(18 - k)}); else n_pass++;
         end
      end
      n_chk++; if (n_done !== 0 || st0 !== 2'b11) $display("FAIL loop_no_done: done count %0d state %0d want 0 3", n_done, st0); else n_pass++;
   endtask

   task automatic test_reset_mid_play();
      run_to(2030);
      rst_n = 1'b0;
      #1;
      n_chk++; if (st0 !== 2'b00 || st1 !== 2'b00) $display("FAIL midreset_state: got %0d %0d want 0 0", st0, st1); else n_pass++;
      n_chk++; if (pos0 !== {6'd32, 6'd32} || pos1 !== {6'd32, 6'd32}) $display("FAIL midreset_pos: got %h %h want %h", pos0, pos1, {6'd32, 6'd32}); else n_pass++;
      n_chk++; if (rl0 !== 3'd0 || full0 !== 1'b0 || pwm0 !== 2'b00) $display("FAIL midreset_regs: rec_len %0d full %b pwm %b want 0 0 00", rl0, full0, pwm0); else n_pass++;
      loop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_play_empty();
      run_to(10);
      pulse_start(2'b11);
      n_chk++; if (st0 !== 2'b11 || done0 !== 1'b0) $display("FAIL empty_entry: state %0d done %b want 3 0", st0, done0); else n_pass++;
      tick();
      n_chk++; if (done0 !== 1'b1 || st0 !== 2'b00) $display("FAIL empty_done: done %b state %0d want 1 0", done0, st0); else n_pass++;
      tick();
      n_chk++; if (done0 !== 1'b0) $display("FAIL empty_done_clear: got %b want 0", done0); else n_pass++;
      n_chk++; if (pos0 !== {6'd32, 6'd32}) $display("FAIL empty_pos: got %h want %h", pos0, {6'd32, 6'd32}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_live();
      test_rec();
      test_play_once();
      test_play_loop();
      test_reset_mid_play();
      test_play_empty();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/servo_seq.md
# servo_seq

Parametrised multi-channel servo sequencer for the arm: generates one servo PWM output per joint. Each joint position comes from one of two sources: live accelerometer-derived positions, or a trajectory recorded into on-chip RAM and played back. The block adds record, looped playback and per-frame slew limiting, and replaces the fixed three-servo ROM-playback FSM and separate PWM instances.

## Interface
Parameters:
- NUM_CH, 3: number of servo channels.
- DATA_W, 8: position width per channel.
- DEPTH, 256: trajectory samples; ADDR_W = clog2(DEPTH).
- PERIOD_CYC, 1_000_000: PWM frame length in clk cycles (20 ms at 50 MHz).
- PULSE_MIN, 50_000: pulse cycles at position 0.
- STEP_CYC, 196: pulse cycles added per position LSB.
- SLEW_MAX, 4: max position change per frame per channel; 0 = unlimited.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: PWM output enable; 0 forces pwm_out low. Counters keep running.
- start, in, 1: one-cycle command strobe; latches cmd_mode.
- cmd_mode, in, 2: 00 IDLE, 01 LIVE, 10 REC, 11 PLAY.
- loop, in, 1: PLAY wraps instead of ending; sampled continuously.
- live_pos, in, NUM_CH*DATA_W: live positions, channel i at bits [i*DATA_W +: DATA_W].
- pwm_out, out, NUM_CH: servo pulses.
- pos_out, out, NUM_CH*DATA_W: current (slewed) positions.
- state, out, 2: current state, same encoding as cmd_mode.
- rec_len, out, ADDR_W+1: number of recorded samples.
- full, out, 1: last REC stopped on DEPTH.
- done, out, 1: one-cycle pulse when non-looping PLAY ends.

## Operation
- frame_cnt counts 0..PERIOD_CYC-1 and wraps. The sample point is frame_cnt==PERIOD_CYC/2. The frame end is frame_cnt==PERIOD_CYC-1.
- start with any cmd_mode enters that state on the next cycle. It clears done. It does not reset frame_cnt.
- IDLE: target holds; pos keeps slewing toward target.
- LIVE: at each sample point, target <= live_pos.
- REC: on entry, wr_ptr <= 0, rec_len <= 0, full <= 0.
  - At each sample point, mem[wr_ptr] <= live_pos, target <= live_pos, and wr_ptr and rec_len increment.
  - When rec_len reaches DEPTH, full <= 1 and the state goes to IDLE in the same cycle.
  - Leaving REC via start keeps the partial rec_len.
- PLAY: on entry, rd_ptr <= 0.
  - A read is issued at sample point minus 1; target <= mem data at the sample point; rd_ptr then increments.
  - After the sample at rec_len-1: if loop=1, rd_ptr <= 0; else done pulses for one cycle and the state goes to IDLE holding the last target.
  - PLAY with rec_len==0: next cycle done pulses, state IDLE, target unchanged.
- Slew, at frame end, per channel: pos moves toward target by min(|target-pos|, SLEW_MAX). If SLEW_MAX==0, pos <= target. The arithmetic is unsigned DATA_W with no wrap.
- Pulse: pulse_cyc[i] = PULSE_MIN + pos[i]*STEP_CYC, width clog2(PERIOD_CYC+1). pulse_cyc must be <= PERIOD_CYC; an elaboration-time check enforces this for the maximum pos.
- pwm_out[i] <= en && (frame_cnt < pulse_cyc[i]).
- Reset values:
  - frame_cnt 0, state IDLE.
  - pos and target = 2**(DATA_W-1) on every channel.
  - wr_ptr, rd_ptr and rec_len 0.
  - full 0, done 0, pwm_out 0.
  - RAM contents undefined.
- Reset mid-REC or mid-PLAY aborts immediately to reset values.

## Timing
- pos changes only at the frame-end edge, so pulse width is constant within a frame (glitch-free).
- pwm_out is registered: it rises the cycle after frame_cnt==0 and is high for exactly pulse_cyc cycles.
- Live-to-PWM latency: a live_pos change is taken at the next sample point, applied at the following frame end, and visible on the next frame pulse. That is at most 1.5 frames plus 1 cycle when no slew limiting applies.
- Sample timing:
  - REC writes exactly one sample per frame.
  - PLAY reads exactly one sample per frame.
  - RAM read latency is 1 cycle, hidden by issuing the read at sample point minus 1.
- If start coincides with a sample point, the new state takes effect next cycle and that sample is processed under the old state.
- If start coincides with REC reaching DEPTH, start wins and full is still set.

## Structure
- Package servo_seq_pkg holds the mode/state localparams (ST_IDLE, ST_LIVE, ST_REC, ST_PLAY) and a center-position function.
- One sub-module: servo_seq_ram.
  - Simple dual-port, NUM_CH*DATA_W wide by DEPTH.
  - Synchronous write; synchronous read with 1-cycle latency; infers M9K.
- Slew, pulse compare and pointers live in the top; channels are generated with a generate loop.

## Test plan
Parameters for all scenarios unless stated: PERIOD_CYC=100, PULSE_MIN=10, STEP_CYC=1, DEPTH=4, SLEW_MAX=0.
- Reset release, en=1: every pwm_out high for 138 cycles per 100-cycle frame? No; use DATA_W=6 (center 32). pwm_out high for 42 cycles per frame, state=IDLE, rec_len=0.
- LIVE, live_pos ch0=0 and ch1=50: within 2 frames, ch0 pulse is 10 cycles and ch1 pulse is 60 cycles; en=0 forces all pwm_out low.
- REC of 6 frames with live_pos stepping 1,2,3,4,5,6: full=1, rec_len=4, state IDLE after the 4th sample, RAM holds 1..4.
- PLAY, loop=0: target sequence 1,2,3,4, one per frame; done pulses once; state IDLE; pos stays 4.
- PLAY, loop=1, with SLEW_MAX=1 starting from pos 32 and target 1: pos decreases by exactly 1 per frame. Sequence wraps 4 to 1 with no done. Reset mid-play gives pos=32 and state IDLE.
- PLAY with rec_len=0: done pulses one cycle after start; pos unchanged.
